// File: rtl/program_sequencer_if.sv
// Host loader port of the program sequencer.
// The host drives the request, write strobe, address and data. The sequencer answers with a grant.
//   master : host side   (drives host_req/host_we/host_addr/host_data, reads host_gnt)
//   slave  : sequencer   (reads host_req/host_we/host_addr/host_data, drives host_gnt)
interface program_sequencer_if #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned PM_W = 8
);
  logic            host_req;
  logic            host_we;
  logic [PC_W-1:0] host_addr;
  logic [PM_W-1:0] host_data;
  logic            host_gnt;

  modport master (
    output host_req,
    output host_we,
    output host_addr,
    output host_data,
    input  host_gnt
  );

  modport slave (
    input  host_req,
    input  host_we,
    input  host_addr,
    input  host_data,
    output host_gnt
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter and program-memory port controller for the 8-bit micro.
// Each cycle it picks the fetch address from the decoder's jump outputs and the ALU zero flag.
// It hands the single PM port to an external host loader through a req/gnt handshake.
// It holds the decoder in its NOP state (core_hold) while the core is parked.
// Ports:
//   clk, sync_reset_n       clock, synchronous active-low reset
//   jmp, jmp_nz, ir_nibble  decoder jump controls and target nibble for the instruction in ir
//   dont_jmp                ALU zero flag; 1 means jmp_nz is not taken
//   host                    host loader port (req/we/addr/data in, gnt out)
//   pm_addr/pm_we/pm_wdata  PM port (combinational)
//   pc                      address of the instruction currently held in the decoder ir
//   core_hold               forces the decoder to its reset/NOP state
module program_sequencer #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned PM_W = 8
) (
  input  logic                clk,
  input  logic                sync_reset_n,
  input  logic                jmp,
  input  logic                jmp_nz,
  input  logic [3:0]          ir_nibble,
  input  logic                dont_jmp,
  program_sequencer_if.slave  host,
  output logic [PC_W-1:0]     pm_addr,
  output logic                pm_we,
  output logic [PM_W-1:0]     pm_wdata,
  output logic [PC_W-1:0]     pc,
  output logic                core_hold
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLoad   = 2'd1,
    StResume = 2'd2
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            gnt_q;
  logic            hold_q;

  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            take_jump;

  assign target    = {ir_nibble, {(PC_W - 4){1'b0}}};
  assign pc_inc    = pc_q + {{(PC_W - 1){1'b0}}, 1'b1};
  // jmp and a taken jmp_nz share the same target, so jmp priority needs no extra mux.
  assign take_jump = jmp | (jmp_nz & ~dont_jmp);

  // The reset edge must fetch address 0 so ir holds PM[0] in the first cycle after reset.
  always_comb begin
    pm_addr = '0;
    pm_we   = 1'b0;
    if (sync_reset_n) begin
      case (state_q)
        StRun:    pm_addr = take_jump ? target : pc_inc;
        StLoad: begin
          pm_addr = host.host_addr;
          pm_we   = host.host_we & host.host_req;
        end
        StResume: pm_addr = pc_q;
        default:  pm_addr = pc_inc;
      endcase
    end
  end

  assign pm_wdata      = host.host_data;
  assign pc            = pc_q;
  // Reset overrides the registered grant/hold at once, so a reset mid-LOAD drops the grant.
  assign host.host_gnt = gnt_q & sync_reset_n;
  assign core_hold     = hold_q | ~sync_reset_n;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q <= StRun;
      pc_q    <= '0;
      gnt_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          // The current instruction still completes, including its jump, before parking.
          pc_q <= pm_addr;
          if (host.host_req) begin
            state_q <= StLoad;
            gnt_q   <= 1'b1;
            hold_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (!host.host_req) begin
            state_q <= StResume;
            gnt_q   <= 1'b0;
            hold_q  <= 1'b1;
          end
        end
        StResume: begin
          // ir still holds host-port data here; refetch pc and release the core next cycle.
          state_q <= StRun;
          gnt_q   <= 1'b0;
          hold_q  <= 1'b0;
        end
        default: begin
          state_q <= StRun;
          gnt_q   <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic       clk;
  logic       sync_reset_n;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] ir_nibble;
  logic       dont_jmp;
  logic [7:0] pm_addr;
  logic       pm_we;
  logic [7:0] pm_wdata;
  logic [7:0] pc;
  logic       core_hold;

  program_sequencer_if #(.PC_W(8), .PM_W(8)) hif ();

  program_sequencer #(.PC_W(8), .PM_W(8)) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .ir_nibble    (ir_nibble),
    .dont_jmp     (dont_jmp),
    .host         (hif.slave),
    .pm_addr      (pm_addr),
    .pm_we        (pm_we),
    .pm_wdata     (pm_wdata),
    .pc           (pc),
    .core_hold    (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory with a registered read into the decoder ir.
  logic [7:0] pm [256];
  logic [7:0] ir;

  function automatic logic [7:0] pm_init(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    ir <= pm[pm_addr];
    if (pm_we) pm[pm_addr] <= pm_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pm[i] = pm_init(i);
    sync_reset_n  = 1'b0;
    jmp           = 1'b0;
    jmp_nz        = 1'b0;
    ir_nibble     = 4'h0;
    dont_jmp      = 1'b0;
    hif.host_req  = 1'b1;
    hif.host_we   = 1'b1;
    hif.host_addr = 8'h77;
    hif.host_data = 8'hEE;

    // Reset held: host request must not be granted.
    tick();
    tick();
    #1;
    check("rst_pm_addr", pm_addr, 8'h00);
    check("rst_core_hold", core_hold, 1'b1);
    check("rst_host_gnt", hif.host_gnt, 1'b0);
    check("rst_pm_we", pm_we, 1'b0);

    // First post-reset cycle executes address 0.
    hif.host_req = 1'b0;
    hif.host_we  = 1'b0;
    sync_reset_n = 1'b1;
    #1;
    check("post_rst_pc", pc, 8'h00);
    check("post_rst_ir", ir, 8'h5A);
    check("post_rst_hold", core_hold, 1'b0);
    check("post_rst_addr", pm_addr, 8'h01);

    // Free run through wrap-around.
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("run_pc", pc, 32'(i % 256));
    end
    check("run_ir", ir, 8'h5A);
    check("run_hold", core_hold, 1'b0);

    // Unconditional jump at pc=0x05.
    repeat (5) tick();
    check("pc5", pc, 8'h05);
    jmp = 1'b1;
    ir_nibble = 4'hA;
    #1;
    check("jmp_addr", pm_addr, 8'hA0);
    tick();
    jmp = 1'b0;
    check("jmp_pc", pc, 8'hA0);
    check("jmp_ir", ir, 8'hFA);

    // Conditional jump taken, then not taken.
    jmp_nz = 1'b1;
    ir_nibble = 4'h3;
    dont_jmp = 1'b0;
    #1;
    check("jnz_taken_addr", pm_addr, 8'h30);
    tick();
    check("jnz_taken_pc", pc, 8'h30);
    dont_jmp = 1'b1;
    #1;
    check("jnz_not_addr", pm_addr, 8'h31);
    tick();
    check("jnz_not_pc", pc, 8'h31);

    // Both jumps with dont_jmp=1: jmp wins, target 0xF0.
    jmp = 1'b1;
    ir_nibble = 4'hF;
    #1;
    check("both_addr", pm_addr, 8'hF0);
    tick();
    check("both_pc", pc, 8'hF0);
    ir_nibble = 4'h1;
    tick();
    jmp = 1'b0;
    jmp_nz = 1'b0;
    dont_jmp = 1'b0;
    check("j10_pc", pc, 8'h10);
    tick();
    tick();
    check("pc12", pc, 8'h12);

    // Host request at pc=0x12 with a sequential instruction.
    hif.host_req = 1'b1;
    #1;
    check("req_addr", pm_addr, 8'h13);
    check("req_gnt_run", hif.host_gnt, 1'b0);
    check("req_hold_run", core_hold, 1'b0);
    tick();
    check("load_pc", pc, 8'h13);
    check("load_gnt", hif.host_gnt, 1'b1);
    check("load_hold", core_hold, 1'b1);
    check("load_we_idle", pm_we, 1'b0);
    hif.host_we   = 1'b1;
    hif.host_addr = 8'h13;
    hif.host_data = 8'h55;
    #1;
    check("load_we", pm_we, 1'b1);
    check("load_addr", pm_addr, 8'h13);
    check("load_wdata", pm_wdata, 8'h55);
    tick();
    check("load_pc_frozen", pc, 8'h13);
    hif.host_req = 1'b0;
    #1;
    check("drop_we", pm_we, 1'b0);
    check("drop_gnt", hif.host_gnt, 1'b1);
    tick();
    // RESUME; a fresh request here is ignored.
    hif.host_we  = 1'b0;
    hif.host_req = 1'b1;
    #1;
    check("resume_hold", core_hold, 1'b1);
    check("resume_addr", pm_addr, 8'h13);
    check("resume_gnt", hif.host_gnt, 1'b0);
    check("resume_we", pm_we, 1'b0);
    tick();
    check("rerun_pc", pc, 8'h13);
    check("rerun_ir", ir, 8'h55);
    check("rerun_hold", core_hold, 1'b0);
    check("rerun_gnt", hif.host_gnt, 1'b0);
    tick();
    check("reload_pc", pc, 8'h14);
    check("reload_gnt", hif.host_gnt, 1'b1);
    hif.host_req = 1'b0;
    tick();
    tick();
    check("rerun2_pc", pc, 8'h14);
    check("rerun2_ir", ir, 8'h4E);
    check("rerun2_hold", core_hold, 1'b0);

    // Host request together with a taken jump.
    jmp = 1'b1;
    ir_nibble = 4'h2;
    hif.host_req = 1'b1;
    #1;
    check("jreq_addr", pm_addr, 8'h20);
    tick();
    jmp = 1'b0;
    check("jreq_pc", pc, 8'h20);
    check("jreq_gnt", hif.host_gnt, 1'b1);
    hif.host_req = 1'b0;
    tick();
    check("jres_addr", pm_addr, 8'h20);
    check("jres_hold", core_hold, 1'b1);
    tick();
    check("jrun_pc", pc, 8'h20);
    check("jrun_ir", ir, 8'h7A);

    // Reset in the middle of LOAD with a pending write.
    hif.host_req = 1'b1;
    tick();
    check("rl_pc", pc, 8'h21);
    hif.host_we   = 1'b1;
    hif.host_addr = 8'h00;
    hif.host_data = 8'hC3;
    #1;
    check("rl_we_pre", pm_we, 1'b1);
    sync_reset_n = 1'b0;
    #1;
    check("rl_we", pm_we, 1'b0);
    check("rl_gnt", hif.host_gnt, 1'b0);
    check("rl_hold", core_hold, 1'b1);
    check("rl_addr", pm_addr, 8'h00);
    tick();
    sync_reset_n = 1'b1;
    hif.host_req = 1'b0;
    hif.host_we  = 1'b0;
    #1;
    check("rl_run_pc", pc, 8'h00);
    check("rl_run_ir", ir, 8'h5A);
    check("rl_run_hold", core_hold, 1'b0);
    check("rl_run_gnt", hif.host_gnt, 1'b0);
    check("rl_run_addr", pm_addr, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
